qs_ucode_seq: RTL and testbench

- Microcode sequencer for the quicksort engine. Owns the program counter and drives the control-store lookup address.
- Resolves control-flow instructions (Jcc, CALL, RET, WAIT, EMIT) locally, owns the BLINK link register and call-depth tracking.
- Dispatches all other instructions to the execute datapath over a valid/ready handshake.
- Sits between the control-store ROM and the register-file/ALU/memory datapath.

---
 rtl/qs_ucode_seq.sv | 196 +++++++++++++++++++
 tb/tb_qs_ucode_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qs_ucode_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qs_ucode_seq                                                  |
// | Purpose  : Microcode sequencer for the quicksort engine. Owns the PC,    |
// |            resolves control flow (Jcc/CALL/RET/WAIT/EMIT) locally, keeps |
// |            the BLINK link register and call depth, and dispatches all    |
// |            other instructions to the datapath over valid/ready.          |
// | Ports    : clk, arst_n            clock / async active-low reset         |
// |            rom_ra, rom_rout       control-store address / instruction    |
// |            exe_vld/inst/rdy/busy  datapath dispatch handshake + busy     |
// |            flag_eq, flag_gt       condition flags from last SUB          |
// |            blink, blink_wr_*      link register read / POP writeback     |
// |            queue_rdy              releases WAIT                          |
// |            emit_vld, emit_rdy     sort-complete handshake                |
// |            depth, err             call depth / sticky fault              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module qs_ucode_seq #(
  parameter int PC_W      = 8,
  parameter int INST_W    = 16,
  parameter int RESET_PC  = 0,
  parameter int MAX_DEPTH = 15
) (
  input  logic                           clk,
  input  logic                           arst_n,
  output logic [PC_W-1:0]                rom_ra,
  input  logic [INST_W-1:0]              rom_rout,
  output logic                           exe_vld,
  output logic [INST_W-1:0]              exe_inst,
  input  logic                           exe_rdy,
  input  logic                           exe_busy,
  input  logic                           flag_eq,
  input  logic                           flag_gt,
  output logic [PC_W-1:0]                blink,
  input  logic                           blink_wr_en,
  input  logic [PC_W-1:0]                blink_wr_data,
  input  logic                           queue_rdy,
  output logic                           emit_vld,
  input  logic                           emit_rdy,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic                           err
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [DEPTH_W-1:0] c_max_depth = DEPTH_W'(MAX_DEPTH);
  localparam logic [PC_W-1:0]    c_reset_pc  = PC_W'(RESET_PC);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    blink_q, blink_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;

  // Instruction decode
  logic [3:0]      w_op;
  logic            w_sub;
  logic [1:0]      w_cc;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_is_nop, w_is_jmp, w_is_cr, w_is_wx, w_is_dp;
  logic            w_cc_true;

  assign w_op     = rom_rout[15:12];
  assign w_sub    = rom_rout[11];
  assign w_cc     = rom_rout[9:8];
  assign w_target = PC_W'(rom_rout[7:0]);
  assign w_pc_inc = pc_q + 1'b1;  // wraps mod 2^PC_W

  assign w_is_nop = (w_op == 4'b0000);
  assign w_is_jmp = (w_op == 4'b0001);
  assign w_is_cr  = (w_op == 4'b1100);  // CALL (sub=0) / RET (sub=1)
  assign w_is_wx  = (w_op == 4'b1111);  // WAIT (sub=0) / EMIT (sub=1)
  assign w_is_dp  = (w_op == 4'b0010) || (w_op == 4'b0100) ||
                    (w_op == 4'b0110) || (w_op == 4'b0111);

  always_comb begin
    w_cc_true = 1'b1;
    case (w_cc)
      2'b01:   w_cc_true = flag_eq;
      2'b10:   w_cc_true = flag_gt;
      2'b11:   w_cc_true = !flag_gt;
      default: w_cc_true = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_RUN;
      pc_q    <= c_reset_pc;
      blink_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      blink_q <= blink_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    blink_d = blink_q;
    depth_d = depth_q;
    err_d   = err_q;

    // POP BLINK writeback; a CALL below overrides it in the same cycle.
    if (blink_wr_en) blink_d = blink_wr_data;

    case (state_q)
      S_RUN: begin
        if (w_is_nop) begin
          pc_d = w_pc_inc;
        end else if (w_is_dp) begin
          if (exe_rdy) pc_d = w_pc_inc;
        end else if (w_is_jmp) begin
          if (w_cc == 2'b00) begin
            // Unconditional jump to itself would spin forever: treat as fault.
            if (w_target == pc_q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              pc_d = w_target;
            end
          end else if (!exe_busy) begin
            // Flags are only final once the datapath has retired everything.
            pc_d = w_cc_true ? w_target : w_pc_inc;
          end
        end else if (w_is_cr) begin
          if (!exe_busy) begin
            if (!w_sub) begin
              if (depth_q == c_max_depth) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end else begin
                blink_d = w_pc_inc;
                pc_d    = w_target;
                depth_d = depth_q + 1'b1;
              end
            end else begin
              if (depth_q == '0) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end else begin
                pc_d    = blink_q;
                depth_d = depth_q - 1'b1;
              end
            end
          end
        end else if (w_is_wx) begin
          if (w_sub) begin
            state_d = S_EMIT;
          end else if (queue_rdy) begin
            pc_d = w_pc_inc;
          end
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_EMIT: begin
        if (emit_rdy) begin
          pc_d    = w_pc_inc;
          state_d = S_RUN;
        end
      end
      default: begin
        // S_ERR: everything frozen until reset.
      end
    endcase
  end

  // Outputs
  always_comb begin
    rom_ra   = pc_q;
    exe_inst = rom_rout;
    // Reset gates valid directly so an in-flight dispatch drops immediately,
    // even though pc_q is parked on an instruction that may be a datapath op.
    exe_vld  = arst_n && (state_q == S_RUN) && w_is_dp;
    emit_vld = (state_q == S_EMIT);
    blink    = blink_q;
    depth    = depth_q;
    err      = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_qs_ucode_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_qs_ucode_seq                                               |
// | Purpose  : Directed self-checking bench for qs_ucode_seq with a ROM      |
// |            model held in a bench array.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_qs_ucode_seq;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  rom_ra;
  logic [15:0] rom_rout;
  logic        exe_vld;
  logic [15:0] exe_inst;
  logic        exe_rdy, exe_busy, flag_eq, flag_gt;
  logic [7:0]  blink;
  logic        blink_wr_en;
  logic [7:0]  blink_wr_data;
  logic        queue_rdy;
  logic        emit_vld, emit_rdy;
  logic [3:0]  depth;
  logic        err;

  logic [15:0] rom [0:255];
  int checks   = 0;
  int failures = 0;

  assign rom_rout = rom[rom_ra];

  always #5 clk = ~clk;

  qs_ucode_seq #(.PC_W(8), .INST_W(16), .RESET_PC(0), .MAX_DEPTH(15)) dut (
    .clk(clk), .arst_n(arst_n), .rom_ra(rom_ra), .rom_rout(rom_rout),
    .exe_vld(exe_vld), .exe_inst(exe_inst), .exe_rdy(exe_rdy),
    .exe_busy(exe_busy), .flag_eq(flag_eq), .flag_gt(flag_gt),
    .blink(blink), .blink_wr_en(blink_wr_en), .blink_wr_data(blink_wr_data),
    .queue_rdy(queue_rdy), .emit_vld(emit_vld), .emit_rdy(emit_rdy),
    .depth(depth), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // POP BLINK writeback must never coincide with a CALL being resolved.
  always @(negedge clk) begin
    if (arst_n && blink_wr_en) begin
      checks++;
      assert (rom_rout[15:11] !== 5'b11000) else begin
        failures++;
        $error("FAIL blink_wr_call_excl observed=%0h expected=not_call", rom_rout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; exe_rdy = 1'b0; exe_busy = 1'b0; flag_eq = 1'b0;
    flag_gt = 1'b0; blink_wr_en = 1'b0; blink_wr_data = 8'h00;
    queue_rdy = 1'b0; emit_rdy = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0]   = 16'h1020;  // J 32
    rom[32]  = 16'hF000;  // WAIT
    rom[33]  = 16'h2155;  // MOVI
    rom[35]  = 16'hC060;  // CALL 96
    rom[36]  = 16'hF800;  // EMIT
    rom[37]  = 16'hC800;  // RET at depth 0 -> fault
    rom[96]  = 16'h1264;  // JGT 100
    rom[100] = 16'h1368;  // JLE 104
    rom[104] = 16'h1074;  // J 116
    rom[116] = 16'hC800;  // RET

    tick(); tick();
    chk("rst_rom_ra", rom_ra, 0);
    chk("rst_exe_vld", exe_vld, 0);
    chk("rst_emit_vld", emit_vld, 0);
    chk("rst_err", err, 0);
    chk("rst_depth", depth, 0);
    chk("rst_blink", blink, 0);
    arst_n = 1'b1;

    // J 32 then WAIT
    tick(); chk("j32", rom_ra, 32);
    tick(); chk("wait_hold", rom_ra, 32);
    queue_rdy = 1'b1;
    tick(); chk("wait_release", rom_ra, 33);
    queue_rdy = 1'b0;

    // MOVI with ready low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      chk("movi_vld", exe_vld, 1);
      chk("movi_inst", exe_inst, 16'h2155);
      chk("movi_hold", rom_ra, 33);
      tick();
    end
    exe_rdy = 1'b1;
    chk("movi_vld4", exe_vld, 1);
    tick(); chk("movi_adv", rom_ra, 34);
    exe_rdy = 1'b0;
    chk("nop_no_vld", exe_vld, 0);

    // POP BLINK writeback at the NOP
    blink_wr_en = 1'b1; blink_wr_data = 8'hAB;
    tick(); blink_wr_en = 1'b0;
    chk("blink_wr", blink, 8'hAB);
    chk("pc35", rom_ra, 35);

    // CALL 96
    tick();
    chk("call_ra", rom_ra, 96);
    chk("call_blink", blink, 36);
    chk("call_depth", depth, 1);

    // JGT stalled on busy, then taken
    exe_busy = 1'b1; flag_gt = 1'b1;
    tick(); chk("jgt_stall1", rom_ra, 96);
    tick(); chk("jgt_stall2", rom_ra, 96);
    exe_busy = 1'b0;
    tick(); chk("jgt_taken", rom_ra, 100);

    // JLE stalled on busy, then taken with flag_gt=0
    exe_busy = 1'b1; flag_gt = 1'b0;
    tick(); chk("jle_stall1", rom_ra, 100);
    tick(); chk("jle_stall2", rom_ra, 100);
    exe_busy = 1'b0;
    tick(); chk("jle_taken", rom_ra, 104);

    tick(); chk("j116", rom_ra, 116);
    tick();
    chk("ret_ra", rom_ra, 36);
    chk("ret_depth", depth, 0);
    chk("ret_no_emit", emit_vld, 0);

    // EMIT with ready after 2 cycles
    tick();
    chk("emit_vld1", emit_vld, 1);
    chk("emit_hold", rom_ra, 36);
    tick(); chk("emit_vld2", emit_vld, 1);
    emit_rdy = 1'b1;
    chk("emit_vld3", emit_vld, 1);
    tick(); emit_rdy = 1'b0;
    chk("emit_adv", rom_ra, 37);
    chk("emit_drop", emit_vld, 0);

    // Fault: RET at depth 0
    tick();
    chk("ret0_err", err, 1);
    chk("ret0_ra", rom_ra, 37);
    tick(); tick();
    chk("ret0_frozen", rom_ra, 37);
    chk("ret0_err_sticky", err, 1);

    // Reset pulse clears everything
    arst_n = 1'b0; #1;
    chk("rst2_ra", rom_ra, 0);
    chk("rst2_err", err, 0);
    chk("rst2_blink", blink, 0);
    for (int i = 0; i < 16; i++) rom[i] = 16'hC000 | 16'(i + 1);  // CALL i+1
    arst_n = 1'b1;

    // Fault: 16th nested CALL
    repeat (15) tick();
    chk("nest_depth15", depth, 15);
    chk("nest_ra15", rom_ra, 15);
    chk("nest_no_err", err, 0);
    tick();
    chk("nest_err", err, 1);
    chk("nest_ra_frozen", rom_ra, 15);
    chk("nest_depth_held", depth, 15);
    chk("nest_blink", blink, 15);
    tick(); chk("nest_frozen2", rom_ra, 15);

    // Fault: illegal opcode 0011
    arst_n = 1'b0; #1;
    rom[0] = 16'h3000;
    arst_n = 1'b1; #1;
    chk("ill_pre_err", err, 0);
    tick();
    chk("ill_err", err, 1);
    tick(); chk("ill_frozen", rom_ra, 0);

    // Reset drops a pending dispatch
    arst_n = 1'b0; #1;
    rom[0] = 16'h2155;
    arst_n = 1'b1; #1;
    chk("pend_vld", exe_vld, 1);
    tick(); chk("pend_hold", rom_ra, 0);
    arst_n = 1'b0; #1;
    chk("pend_drop", exe_vld, 0);

    // PC wrap 255 -> 0
    rom[0] = 16'h10FF; rom[255] = 16'h0000;
    arst_n = 1'b1;
    tick(); chk("j255", rom_ra, 255);
    tick(); chk("wrap", rom_ra, 0);

    // Fault: J 128 at pc 128
    rom[0] = 16'h1080; rom[128] = 16'h1080;
    tick(); chk("j128", rom_ra, 128);
    chk("j128_no_err", err, 0);
    tick();
    chk("self_j_err", err, 1);
    chk("self_j_ra", rom_ra, 128);
    tick(); chk("self_j_frozen", rom_ra, 128);
    chk("err_no_vld", exe_vld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
